// File: rtl/change_dispenser.sv
// Coin-change payout controller: greedy HI/MID/LO selection, one coin per ack, settle gap between coins.
// Optional ack watchdog enabled by defining CHANGE_TIMEOUT_EN.
module change_dispenser #(
    parameter int DENOM_HI    = 5,
    parameter int DENOM_MID   = 2,
    parameter int DENOM_LO    = 1,
    parameter int ACK_TIMEOUT = 255,
    parameter int GAP_CYCLES  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       change_returning,
    input  logic [7:0] change_due,
    input  logic [2:0] hopper_empty,
    input  logic       eject_ack,
    output logic       eject_req,
    output logic [1:0] eject_sel,
    output logic       busy,
    output logic       done_pulse,
    output logic       fault,
    output logic [7:0] remaining,
    output logic [7:0] coins_paid
);

    typedef enum logic [2:0] {IDLE, SELECT, EJECT, GAP, DONE, FAULT} state_t;

    localparam logic [7:0]  DENOM_TAB [3] = '{8'(DENOM_LO), 8'(DENOM_MID), 8'(DENOM_HI)};
    localparam logic [15:0] GAP_LAST = (GAP_CYCLES > 1) ? 16'(GAP_CYCLES - 1) : 16'd0;

    state_t      state_reg, state_next;
    logic        eject_req_reg, eject_req_next;
    logic [1:0]  eject_sel_reg, eject_sel_next;
    logic [7:0]  remaining_reg, remaining_next;
    logic [7:0]  coins_paid_reg, coins_paid_next;
    logic [15:0] gap_cnt_reg, gap_cnt_next;
    logic [7:0]  denom_cur;
    logic [2:0]  coin_ok;

`ifdef CHANGE_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = (ACK_TIMEOUT > 1) ? 16'(ACK_TIMEOUT - 1) : 16'd0;
    logic [15:0] tmo_cnt_reg, tmo_cnt_next;
`endif

    // A coin qualifies when its hopper has stock and it does not overpay.
    for (genvar gi = 0; gi < 3; gi++) begin : g_coin_ok
        assign coin_ok[gi] = !hopper_empty[gi] && (remaining_reg >= DENOM_TAB[gi]);
    end

    always_comb begin
        case (eject_sel_reg)
            2'd2:    denom_cur = DENOM_TAB[2];
            2'd1:    denom_cur = DENOM_TAB[1];
            default: denom_cur = DENOM_TAB[0];
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            eject_req_reg  <= 1'b0;
            eject_sel_reg  <= 2'd0;
            remaining_reg  <= 8'd0;
            coins_paid_reg <= 8'd0;
            gap_cnt_reg    <= 16'd0;
`ifdef CHANGE_TIMEOUT_EN
            tmo_cnt_reg    <= 16'd0;
`endif
        end else begin
            state_reg      <= state_next;
            eject_req_reg  <= eject_req_next;
            eject_sel_reg  <= eject_sel_next;
            remaining_reg  <= remaining_next;
            coins_paid_reg <= coins_paid_next;
            gap_cnt_reg    <= gap_cnt_next;
`ifdef CHANGE_TIMEOUT_EN
            tmo_cnt_reg    <= tmo_cnt_next;
`endif
        end
    end

    always_comb begin
        state_next      = state_reg;
        eject_req_next  = eject_req_reg;
        eject_sel_next  = eject_sel_reg;
        remaining_next  = remaining_reg;
        coins_paid_next = coins_paid_reg;
        gap_cnt_next    = gap_cnt_reg;
`ifdef CHANGE_TIMEOUT_EN
        tmo_cnt_next    = tmo_cnt_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (change_returning && change_due != 8'd0) begin
                    remaining_next  = change_due;
                    coins_paid_next = 8'd0;
                    state_next      = SELECT;
                end
            end
            SELECT: begin
                gap_cnt_next = 16'd0;
`ifdef CHANGE_TIMEOUT_EN
                tmo_cnt_next = 16'd0;
`endif
                if (remaining_reg == 8'd0) begin
                    state_next = DONE;
                end else if (coin_ok[2]) begin
                    eject_sel_next = 2'd2;
                    eject_req_next = 1'b1;
                    state_next     = EJECT;
                end else if (coin_ok[1]) begin
                    eject_sel_next = 2'd1;
                    eject_req_next = 1'b1;
                    state_next     = EJECT;
                end else if (coin_ok[0]) begin
                    eject_sel_next = 2'd0;
                    eject_req_next = 1'b1;
                    state_next     = EJECT;
                end else begin
                    state_next = FAULT;
                end
            end
            EJECT: begin
                if (eject_ack) begin
                    eject_req_next  = 1'b0;
                    remaining_next  = remaining_reg - denom_cur;
                    coins_paid_next = (coins_paid_reg == 8'hFF) ? 8'hFF : coins_paid_reg + 8'd1;
                    gap_cnt_next    = 16'd0;
                    state_next      = GAP;
                end
`ifdef CHANGE_TIMEOUT_EN
                else if (tmo_cnt_reg >= TMO_LAST) begin
                    eject_req_next = 1'b0;
                    state_next     = FAULT;
                end else begin
                    tmo_cnt_next = tmo_cnt_reg + 16'd1;
                end
`endif
            end
            GAP: begin
                if (gap_cnt_reg >= GAP_LAST) begin
                    state_next = SELECT;
                end else begin
                    gap_cnt_next = gap_cnt_reg + 16'd1;
                end
            end
            DONE:    state_next = IDLE;
            FAULT:   state_next = FAULT;
            default: state_next = IDLE;
        endcase
    end

    assign eject_req  = eject_req_reg;
    assign eject_sel  = eject_sel_reg;
    assign remaining  = remaining_reg;
    assign coins_paid = coins_paid_reg;
    assign busy       = (state_reg != IDLE) && (state_reg != FAULT);
    assign done_pulse = (state_reg == DONE);
    assign fault      = (state_reg == FAULT);

endmodule
